// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: clear sweep > debug loader > CPU writeback.
// Register 0 is never written; the PC is stalled whenever the CPU loses the port.
module regfile_write_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIRST_ADDR = 1,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_stall
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  wr_req_t           sel;
  logic              stall, dbg_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= FIRST;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= (state == CLEAR) && (cnt == LAST);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel       = '{we: cpu_we, addr: cpu_waddr, data: cpu_wdata};
    stall     = 1'b0;
    dbg_acc   = 1'b0;
    case (state)
      IDLE: begin
        // A sweep request in the same cycle wins over a pending debug write.
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = FIRST;
        end else if (dbg_valid) begin
          dbg_acc = 1'b1;
          stall   = 1'b1;
          sel     = '{we: 1'b1, addr: dbg_addr, data: dbg_data};
        end
      end
      CLEAR: begin
        stall = 1'b1;
        sel   = '{we: 1'b1, addr: cnt, data: '0};
        if (cnt == LAST) state_nxt = IDLE;
        else             cnt_nxt   = cnt + ADDR_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by reset_n so nothing reaches the register file during reset.
  assign rf_we     = reset_n & sel.we & (|sel.addr);
  assign rf_waddr  = sel.addr;
  assign rf_wdata  = sel.data;
  assign dbg_ready = reset_n & dbg_acc;
  assign cpu_stall = reset_n & stall;
  assign clr_busy  = (state == CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file on the write port.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        clr_req;
  logic        clr_busy, clr_done;
  logic        dbg_valid, dbg_ready;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cpu_stall;

  logic [31:0] regs [32];
  int checks = 0;
  int failures = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0;
    clr_req = 0; dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      cpu_we = 1; cpu_waddr = 5'(i); cpu_wdata = 32'hFFFF_FFFF;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    cpu_we = 1; cpu_waddr = 3; cpu_wdata = 32'h33; dbg_valid = 1; dbg_addr = 6;
    #3;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    tick();
    idle_inputs();
    reset_n = 1;
    tick();

    // 1. CPU passthrough
    cpu_we = 1; cpu_waddr = 2; cpu_wdata = 32'h10E;
    @(negedge clk);
    chk("cpu_rf_we", rf_we, 1);
    chk("cpu_rf_waddr", rf_waddr, 2);
    chk("cpu_rf_wdata", rf_wdata, 32'h10E);
    chk("cpu_stall", cpu_stall, 0);
    tick();
    chk("cpu_reg2", regs[2], 32'h10E);
    idle_inputs();

    // 2. Full clear
    preload();
    chk("preload_reg17", regs[17], 32'hFFFF_FFFF);
    clr_req = 1;
    @(negedge clk);
    chk("clr_req_cycle_busy", clr_busy, 0);
    tick();
    clr_req = 0;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      chk("sweep_busy", clr_busy, 1);
      chk("sweep_addr", rf_waddr, 32'(k + 1));
      chk("sweep_we", rf_we, 1);
      chk("sweep_data", rf_wdata, 0);
      chk("sweep_stall", cpu_stall, 1);
      chk("sweep_no_done", clr_done, 0);
      tick();
    end
    @(negedge clk);
    chk("done_busy", clr_busy, 0);
    chk("done_pulse", clr_done, 1);
    chk("done_stall", cpu_stall, 0);
    tick();
    chk("done_single", clr_done, 0);
    for (int i = 0; i < 32; i++) chk("cleared_reg", regs[i], 0);

    // 3. Debug beats CPU
    dbg_valid = 1; dbg_addr = 5; dbg_data = 32'h8;
    cpu_we = 1; cpu_waddr = 4; cpu_wdata = 32'h44;
    @(negedge clk);
    chk("dbg_ready", dbg_ready, 1);
    chk("dbg_stall", cpu_stall, 1);
    chk("dbg_waddr", rf_waddr, 5);
    tick();
    chk("dbg_reg5", regs[5], 32'h8);
    chk("dbg_reg4_kept", regs[4], 0);
    dbg_valid = 0;
    @(negedge clk);
    chk("retry_stall", cpu_stall, 0);
    tick();
    chk("retry_reg4", regs[4], 32'h44);
    idle_inputs();

    // 4. Collision and lockout, with a re-pulse mid-sweep
    clr_req = 1; dbg_valid = 1; dbg_addr = 7; dbg_data = 32'h77;
    @(negedge clk);
    chk("collide_ready", dbg_ready, 0);
    tick();
    clr_req = 0;
    for (int k = 0; k < 31; k++) begin
      clr_req = (k == 10);
      @(negedge clk);
      chk("lock_ready", dbg_ready, 0);
      chk("lock_busy", clr_busy, 1);
      chk("lock_addr", rf_waddr, 32'(k + 1));
      tick();
    end
    clr_req = 0;
    @(negedge clk);
    chk("lock_end_busy", clr_busy, 0);
    chk("lock_end_done", clr_done, 1);
    chk("lock_end_ready", dbg_ready, 1);
    chk("lock_end_waddr", rf_waddr, 7);
    tick();
    chk("lock_reg7", regs[7], 32'h77);
    dbg_valid = 0;
    @(negedge clk);
    chk("no_restart", clr_busy, 0);
    tick();

    // 5. $zero protection
    cpu_we = 1; cpu_waddr = 0; cpu_wdata = 32'h1234;
    @(negedge clk);
    chk("zero_cpu_we", rf_we, 0);
    chk("zero_cpu_stall", cpu_stall, 0);
    tick();
    cpu_we = 0; dbg_valid = 1; dbg_addr = 0; dbg_data = 32'h55;
    @(negedge clk);
    chk("zero_dbg_ready", dbg_ready, 1);
    chk("zero_dbg_we", rf_we, 0);
    chk("zero_dbg_stall", cpu_stall, 1);
    tick();
    chk("zero_reg0", regs[0], 0);
    idle_inputs();

    // 6. Reset mid-sweep at address 10
    preload();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 9; k++) tick();
    @(negedge clk);
    chk("midrst_addr", rf_waddr, 10);
    #2 reset_n = 0;
    #1;
    chk("midrst_busy", clr_busy, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_done", clr_done, 0);
    tick();
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_done", clr_done, 0);
      chk("postrst_busy", clr_busy, 0);
      tick();
    end
    for (int i = 1; i < 10; i++) chk("midrst_cleared", regs[i], 0);
    for (int i = 11; i < 32; i++) chk("midrst_kept", regs[i], 32'hFFFF_FFFF);
    clr_req = 1;
    tick();
    clr_req = 0;
    @(negedge clk);
    chk("resweep_busy", clr_busy, 1);
    chk("resweep_addr", rf_waddr, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
